// File: rtl/ysyx_25030093_lsu_pkg.sv
// Shared types and constants for the load/store unit.
package ysyx_25030093_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  // RV32 load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/ysyx_25030093_lsu_align.sv
// Byte-lane alignment: store mask/data shifting, load extract/extend and
// misalignment / illegal-width detection. Purely combinational.
module ysyx_25030093_lsu_align
  import ysyx_25030093_lsu_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        fault
);

  logic [3:0]  base;
  logic [31:0] shr;
  logic        legal;
  logic        misal;

  // Width decode, fault detection and lane shifting; load takes priority if both flags set
  always_comb begin
    base  = 4'b0000;
    case (funct3)
      F3_B, F3_BU: base = 4'b0001;
      F3_H, F3_HU: base = 4'b0011;
      F3_W:        base = 4'b1111;
      default:     base = 4'b0000;
    endcase

    if (is_load)
      legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    else
      legal = funct3 inside {F3_B, F3_H, F3_W};

    misal = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
            ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    fault = (is_load || is_store) && (!legal || misal);

    wmask = (is_store && !is_load) ? 4'(base << addr_lo) : 4'b0000;
    wdata = rs2_data << {addr_lo, 3'b000};

    shr = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    ld_data = {{24{shr[7]}}, shr[7:0]};
      F3_H:    ld_data = {{16{shr[15]}}, shr[15:0]};
      F3_BU:   ld_data = {24'b0, shr[7:0]};
      F3_HU:   ld_data = {16'b0, shr[15:0]};
      default: ld_data = shr;
    endcase
  end

endmodule

// File: rtl/ysyx_25030093_lsu.sv
// Single-op load/store unit: accepts one op from execute, issues at most one
// bus request, and hands the write-back value on through a valid/ready port.
module ysyx_25030093_lsu
  import ysyx_25030093_lsu_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_is_load,
  input  logic          in_is_store,
  input  logic [2:0]    in_funct3,
  input  logic [31:0]   in_alu_res,
  input  logic [31:0]   in_rs2_data,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_wen,
  output logic [AW-1:0] mem_req_addr,
  output logic [31:0]   mem_req_wdata,
  output logic [3:0]    mem_req_wmask,
  input  logic          mem_resp_valid,
  input  logic [31:0]   mem_resp_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_wb_data,
  output logic          out_fault
);

  lsu_state_e  state;
  logic        r_is_load, r_is_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_rs2;

  // One aligner serves both phases: live inputs while idle (accept-time
  // fault/mask/data), latched op while waiting (load extraction).
  logic        a_ld, a_st;
  logic [2:0]  a_f3;
  logic [1:0]  a_off;
  logic [31:0] a_rs2;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata, al_ld_data;
  logic        al_fault;
  logic        idle, in_mem;

  assign idle     = (state == S_IDLE);
  assign in_ready = idle;
  assign in_mem   = in_is_load || in_is_store;
  assign a_ld     = idle ? in_is_load       : r_is_load;
  assign a_st     = idle ? in_is_store      : r_is_store;
  assign a_f3     = idle ? in_funct3        : r_funct3;
  assign a_off    = idle ? in_alu_res[1:0]  : r_off;
  assign a_rs2    = idle ? in_rs2_data      : r_rs2;

  ysyx_25030093_lsu_align u_align (
    .is_load  (a_ld),
    .is_store (a_st),
    .funct3   (a_f3),
    .addr_lo  (a_off),
    .rs2_data (a_rs2),
    .rdata    (mem_resp_rdata),
    .wmask    (al_wmask),
    .wdata    (al_wdata),
    .ld_data  (al_ld_data),
    .fault    (al_fault)
  );

  // Control FSM with registered bus and write-back outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      r_is_load     <= 1'b0;
      r_is_store    <= 1'b0;
      r_funct3      <= 3'b0;
      r_off         <= 2'b0;
      r_rs2         <= 32'b0;
      mem_req_valid <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= 32'b0;
      mem_req_wmask <= 4'b0;
      out_valid     <= 1'b0;
      out_wb_data   <= 32'b0;
      out_fault     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          r_is_load  <= in_is_load;
          r_is_store <= in_is_store;
          r_funct3   <= in_funct3;
          r_off      <= in_alu_res[1:0];
          r_rs2      <= in_rs2_data;
          out_fault  <= 1'b0;
          if (!in_mem) begin
            out_valid   <= 1'b1;
            out_wb_data <= in_alu_res;
            state       <= S_DONE;
          end else if (al_fault) begin
            out_valid   <= 1'b1;
            out_fault   <= 1'b1;
            out_wb_data <= 32'b0;
            state       <= S_DONE;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_wen   <= !in_is_load;
            mem_req_addr  <= in_alu_res[AW-1:0];
            mem_req_wdata <= in_is_load ? 32'b0 : al_wdata;
            mem_req_wmask <= al_wmask;
            state         <= S_REQ;
          end
        end
        S_REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          state         <= S_WAIT;
        end
        S_WAIT: if (mem_resp_valid) begin
          out_valid   <= 1'b1;
          out_wb_data <= r_is_load ? al_ld_data : 32'b0;
          state       <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
// Bench for the LSU: spec vector table, randomized ops against a reference
// model, and directed sequences for back-pressure, handshake and reset.
module tb_ysyx_25030093_lsu;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_is_load, in_is_store;
  logic [2:0]    in_funct3;
  logic [31:0]   in_alu_res, in_rs2_data;
  logic          mem_req_valid, mem_req_ready, mem_req_wen;
  logic [AW-1:0] mem_req_addr;
  logic [31:0]   mem_req_wdata;
  logic [3:0]    mem_req_wmask;
  logic          mem_resp_valid;
  logic [31:0]   mem_resp_rdata;
  logic          out_valid, out_ready, out_fault;
  logic [31:0]   out_wb_data;

  int checks = 0;
  int errors = 0;

  ysyx_25030093_lsu #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_alu_res(in_alu_res), .in_rs2_data(in_rs2_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_data(out_wb_data), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] alu, rs2, rdata;
    logic        eflt;
    logic [31:0] ewb;
    logic [3:0]  emask;
    logic [31:0] ewdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: access size from the width code, fault = illegal code or
  // address not a multiple of size; lanes computed with plain arithmetic.
  function automatic void model(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] rs2,
                                input logic [31:0] rdata, output logic flt,
                                output logic [31:0] wb, output logic [3:0] mask,
                                output logic [31:0] wdata);
    int off, size;
    bit legal;
    logic [63:0] v, m;
    flt = 0; wb = 0; mask = 0; wdata = 0;
    if (!ld && !st) begin wb = alu; return; end
    off = int'(alu[1:0]);
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 1;
    endcase
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    if (!legal || (off % size) != 0) begin flt = 1; return; end
    if (st) begin
      m = ((64'd1 << size) - 64'd1) << off;
      mask = m[3:0];
      v = {32'b0, rs2} << (8 * off);
      wdata = v[31:0];
    end else begin
      v = ({32'b0, rdata} >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
      if (!f3[2] && size < 4 && v >= (64'd1 << (8 * size - 1)))
        v = v - (64'd1 << (8 * size));
      wb = v[31:0];
    end
  endfunction

  // Full transaction with programmable request and output back-pressure
  task automatic do_op(input string nm, input vec_t t, input int rlat, input int olat);
    int guard = 0;
    bit bus;
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1; in_is_load = t.ld; in_is_store = t.st; in_funct3 = t.f3;
    in_alu_res = t.alu; in_rs2_data = t.rs2;
    @(negedge clk);
    in_valid = 0; in_is_load = $urandom; in_is_store = $urandom; in_funct3 = 3'($urandom);
    in_alu_res = $urandom; in_rs2_data = $urandom;
    bus = (t.ld || t.st) && !t.eflt;
    if (!bus) begin
      chk({nm, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({nm, ".no_req"}, 32'(mem_req_valid), 32'd0);
    end else begin
      for (int i = 0; i <= rlat; i++) begin
        chk({nm, ".req_valid"}, 32'(mem_req_valid), 32'd1);
        chk({nm, ".wen"}, 32'(mem_req_wen), 32'(t.st));
        chk({nm, ".addr"}, 32'(mem_req_addr), t.alu);
        chk({nm, ".wmask"}, 32'(mem_req_wmask), 32'(t.emask));
        if (t.st) chk({nm, ".wdata"}, mem_req_wdata, t.ewdata);
        chk({nm, ".early_out"}, 32'(out_valid), 32'd0);
        mem_resp_valid = (i < rlat);   // stray strobe outside WAIT must be ignored
        mem_resp_rdata = $urandom;
        mem_req_ready  = (i == rlat);
        @(negedge clk);
      end
      mem_req_ready = 0;
      for (int i = 0; i < rlat % 2; i++) begin
        mem_resp_valid = 0;
        @(negedge clk);
        chk({nm, ".wait_out"}, 32'(out_valid), 32'd0);
      end
      chk({nm, ".req_drop"}, 32'(mem_req_valid), 32'd0);
      mem_resp_valid = 1; mem_resp_rdata = t.rdata;
      @(negedge clk);
      mem_resp_valid = 0; mem_resp_rdata = $urandom;
      chk({nm, ".out_valid"}, 32'(out_valid), 32'd1);
    end
    chk({nm, ".fault"}, 32'(out_fault), 32'(t.eflt));
    chk({nm, ".wb"}, out_wb_data, t.ewb);
    for (int i = 0; i < olat; i++) begin
      @(negedge clk);
      chk({nm, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({nm, ".hold_wb"}, out_wb_data, t.ewb);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({nm, ".out_drop"}, 32'(out_valid), 32'd0);
    chk({nm, ".idle"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[12];
  vec_t r;

  initial begin
    //        ld st f3      alu           rs2           rdata         flt wb            mask     wdata
    vecs[0]  = '{0, 0, 3'd0, 32'h1234,     32'h0,        32'h0,        0, 32'h1234,     4'b0000, 32'h0};
    vecs[1]  = '{0, 1, 3'd0, 32'h80000003, 32'hAB,       32'h0,        0, 32'h0,        4'b1000, 32'hAB000000};
    vecs[2]  = '{1, 0, 3'd1, 32'h2,        32'h0,        32'h80010000, 0, 32'hFFFF8001, 4'b0000, 32'h0};
    vecs[3]  = '{1, 0, 3'd5, 32'h2,        32'h0,        32'h80010000, 0, 32'h00008001, 4'b0000, 32'h0};
    vecs[4]  = '{1, 0, 3'd2, 32'h6,        32'h0,        32'h0,        1, 32'h0,        4'b0000, 32'h0};
    vecs[5]  = '{0, 1, 3'd2, 32'h4,        32'hDEADBEEF, 32'h0,        0, 32'h0,        4'b1111, 32'hDEADBEEF};
    vecs[6]  = '{1, 0, 3'd0, 32'h1,        32'h0,        32'h00008000, 0, 32'hFFFFFF80, 4'b0000, 32'h0};
    vecs[7]  = '{1, 0, 3'd4, 32'h1,        32'h0,        32'h00008000, 0, 32'h00000080, 4'b0000, 32'h0};
    vecs[8]  = '{1, 0, 3'd3, 32'h0,        32'h0,        32'h0,        1, 32'h0,        4'b0000, 32'h0};
    vecs[9]  = '{0, 1, 3'd4, 32'h0,        32'h5,        32'h0,        1, 32'h0,        4'b0000, 32'h0};
    vecs[10] = '{0, 1, 3'd1, 32'h1,        32'h5,        32'h0,        1, 32'h0,        4'b0000, 32'h0};
    vecs[11] = '{0, 1, 3'd1, 32'h2,        32'h1234ABCD, 32'h0,        0, 32'h0,        4'b1100, 32'hABCD0000};

    rst = 1; in_valid = 0; in_is_load = 0; in_is_store = 0; in_funct3 = 0;
    in_alu_res = 0; in_rs2_data = 0; mem_req_ready = 0; mem_resp_valid = 0;
    mem_resp_rdata = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.fault", 32'(out_fault), 32'd0);
    chk("rst.wb", out_wb_data, 32'd0);
    chk("rst.wmask", 32'(mem_req_wmask), 32'd0);
    chk("rst.wdata", mem_req_wdata, 32'd0);
    chk("rst.addr", 32'(mem_req_addr), 32'd0);
    chk("rst.wen", 32'(mem_req_wen), 32'd0);
    rst = 0;
    @(negedge clk);

    foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i], 0, 0);

    // Request held 5 cycles, output held 3 cycles
    do_op("bp_store", vecs[11], 5, 3);
    do_op("bp_load", vecs[2], 5, 3);

    // No accept in the DONE->IDLE handshake cycle
    in_valid = 1; in_is_load = 0; in_is_store = 0; in_alu_res = 32'h77;
    @(negedge clk);
    in_alu_res = 32'h5555; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("hs.out_drop", 32'(out_valid), 32'd0);
    chk("hs.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 0;
    chk("hs.next_valid", 32'(out_valid), 32'd1);
    chk("hs.next_wb", out_wb_data, 32'h5555);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;

    // Randomized ops against the model
    for (int n = 0; n < 40; n++) begin
      int cls;
      cls = $urandom_range(0, 2);
      r.ld = (cls == 1); r.st = (cls == 2);
      r.f3 = 3'($urandom_range(0, 7));
      r.alu = $urandom; r.rs2 = $urandom; r.rdata = $urandom;
      model(r.ld, r.st, r.f3, r.alu, r.rs2, r.rdata, r.eflt, r.ewb, r.emask, r.ewdata);
      do_op($sformatf("rnd%0d", n), r, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset while in WAIT, then a stray response
    in_valid = 1; in_is_load = 1; in_is_store = 0; in_funct3 = 3'd2; in_alu_res = 32'h10;
    @(negedge clk);
    in_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    chk("rw.in_wait", 32'(in_ready), 32'd0);
    #2 rst = 1;
    #1;
    chk("rw.async_ready", 32'(in_ready), 32'd1);
    chk("rw.async_req", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    rst = 0; mem_resp_valid = 1; mem_resp_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_resp_valid = 0;
    chk("rw.out_valid", 32'(out_valid), 32'd0);
    chk("rw.in_ready", 32'(in_ready), 32'd1);
    chk("rw.wb", out_wb_data, 32'd0);
    @(negedge clk);
    chk("rw.out_valid2", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_lsu.md
YSYX_25030093_LSU -- requirements
Module: ysyx_25030093_lsu

Interface
REQ-001 Parameter AW, 32, memory address width; data width SHALL be fixed at 32.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  execute stage has an op to hand over.
REQ-005 in_ready  out  1  LSU accepts an op this cycle.
REQ-006 in_is_load / in_is_store  in  1 each  op class; neither set means a non-memory op.
REQ-007 in_funct3  in  3  RV32 load/store width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 in_alu_res  in  32  effective address, or the result of a non-memory op.
REQ-009 in_rs2_data  in  32  store source data.
REQ-010 mem_req_valid / mem_req_ready  out / in  1 each  bus request handshake.
REQ-011 mem_req_wen  out  1  write request flag.
REQ-012 mem_req_addr  out  AW  request address.
REQ-013 mem_req_wdata  out  32  lane-shifted store data.
REQ-014 mem_req_wmask  out  4  byte-enable mask.
REQ-015 mem_resp_valid  in  1  response strobe.
REQ-016 mem_resp_rdata  in  32  read data, or don't-care for writes.
REQ-017 out_valid / out_ready  out / in  1 each  write-back handshake.
REQ-018 out_wb_data  out  32  value for rd.
REQ-019 out_fault  out  1  misaligned access or illegal funct3.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, DONE; in_ready SHALL equal (state==IDLE).
REQ-021 Accept (in_valid&&in_ready) SHALL register all in_* fields.
- Non-memory op goes to DONE, with out_wb_data=in_alu_res.
- Faulting memory op goes to DONE, with out_fault=1 and out_wb_data=0.
- Otherwise the op goes to REQ.
REQ-022 A fault SHALL be one of:
- h/hu/sh with addr[0]=1;
- w/sw with addr[1:0]!=0;
- a load funct3 outside {000,001,010,100,101};
- a store funct3 outside {000,001,010}.
A faulting op SHALL issue no bus request.
REQ-023 In REQ, mem_req_valid=1 and all mem_req_* SHALL stay stable until mem_req_ready; the handshake cycle moves to WAIT.
REQ-024 In WAIT, mem_resp_valid SHALL move to DONE; mem_resp_valid in any other state SHALL be ignored.
REQ-025 Store: wmask SHALL be 0001, 0011 or 1111 (b/h/w) shifted left by addr[1:0]; wdata SHALL be rs2 shifted left by 8*addr[1:0]; out_wb_data SHALL be 0.
REQ-026 Load: the response SHALL be shifted right by 8*addr[1:0], then sign-extended (b, h) or zero-extended (bu, hu) into out_wb_data; wmask SHALL be 0000.
REQ-027 In DONE, out_valid=1 and outputs SHALL stay stable until out_ready; the handshake cycle returns to IDLE.
REQ-028 Latency SHALL be:
- non-memory or fault: out_valid the cycle after accept;
- memory op: one cycle after the response, with zero-wait minimum of 3 cycles after accept.
REQ-029 The LSU SHALL hold at most one op; a new op SHALL NOT be accepted in the DONE→IDLE handshake cycle.

Reset
REQ-030 rst SHALL force IDLE immediately, regardless of clk.
REQ-031 During and after reset, the following SHALL be 0: mem_req_valid, out_valid, out_fault, out_wb_data, mem_req_* and wmask; in_ready SHALL be 1.
REQ-032 Reset mid-transaction SHALL abandon the op; a later stray mem_resp_valid SHALL be ignored.

Structure
REQ-033 Package ysyx_25030093_lsu_pkg SHALL hold the state enum and the funct3 width constants.
REQ-034 Sub-module ysyx_25030093_lsu_align SHALL contain only combinational logic: wmask/wdata generation, load extract/extend, and fault detection.

Verification
REQ-035 Non-memory op alu_res=0x1234 with out_ready=1 → out_valid one cycle after accept, out_wb_data=0x1234, no mem_req_valid.
REQ-036 sb addr=0x80000003, rs2=0xAB → wmask=1000, wdata=0xAB000000, wen=1, out_wb_data=0.
REQ-037 lh addr=0x2 with rdata=0x80010000 → out_wb_data=0xFFFF8001; lhu with the same inputs → 0x00008001.
REQ-038 lw addr=0x6 → out_fault=1, no bus request, out_valid one cycle after accept.
REQ-039 mem_req_ready held low for 5 cycles → request fields stable all 5 cycles; out_ready held low 3 cycles → out_valid and out_wb_data held.
REQ-040 rst asserted while in WAIT, then mem_resp_valid pulsed → state IDLE, no out_valid, in_ready=1.
